// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI-style memory read channel between the
// i_cache (requester 0) and d_cache (requester 1), one whole burst at a time.
module mem_read_arbiter #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 s_arvalid,
  input  logic [1:0][ADDR_WIDTH-1:0] s_araddr,
  input  logic [1:0][LEN_WIDTH-1:0]  s_arlen,
  output logic [1:0]                 s_arready,
  output logic [1:0]                 s_rvalid,
  output logic [DATA_WIDTH-1:0]      s_rdata,
  output logic                       m_arvalid,
  output logic [ADDR_WIDTH-1:0]      m_araddr,
  output logic [LEN_WIDTH-1:0]       m_arlen,
  output logic [ID_WIDTH-1:0]        m_arid,
  input  logic                       m_arready,
  input  logic                       m_rvalid,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic [ID_WIDTH-1:0]        m_rid,
  output logic                       m_rready,
  output logic                       grant_id,
  output logic                       busy,
  output logic                       err_rid
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    rr_ptr;
  logic                    winner;
  logic                    last_beat;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    beat_cnt;
  logic [LEN_WIDTH:0]      beat_next;
  logic [ID_WIDTH-1:0]     grant_id_ext;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_arready  = '0;
    s_rvalid   = '0;
    last_beat  = 1'b0;
    winner     = s_arvalid[rr_ptr] ? rr_ptr : ~rr_ptr;
    // One extra bit keeps counter+1 from wrapping on a maximum-length burst.
    beat_next  = {1'b0, beat_cnt} + (LEN_WIDTH+1)'(1);
    case (state)
      IDLE: begin
        if (|s_arvalid) state_next = ADDR;
      end
      ADDR: begin
        m_arvalid           = 1'b1;
        s_arready[grant_id] = m_arready;
        if (m_arready) state_next = DATA;
      end
      DATA: begin
        m_rready           = 1'b1;
        s_rvalid[grant_id] = m_rvalid;
        if (m_rvalid && (beat_next == {1'b0, len_q})) begin
          last_beat  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      grant_id <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      err_rid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_arvalid) begin
            grant_id <= winner;
            addr_q   <= s_araddr[winner];
            len_q    <= (s_arlen[winner] == '0) ? LEN_WIDTH'(1) : s_arlen[winner];
          end
        end
        ADDR: begin
          if (m_arready) beat_cnt <= '0;
        end
        DATA: begin
          if (m_rvalid) begin
            beat_cnt <= beat_next[LEN_WIDTH-1:0];
            if (m_rid != grant_id_ext) err_rid <= 1'b1;
            if (last_beat) rr_ptr <= ~grant_id;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant_id_ext = {{(ID_WIDTH-1){1'b0}}, grant_id};
  assign m_araddr     = addr_q;
  assign m_arlen      = len_q;
  assign m_arid       = grant_id_ext;
  assign s_rdata      = m_rdata;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a burst-level model.
module tb_mem_read_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          s_arvalid;
  logic [1:0][AW-1:0]  s_araddr;
  logic [1:0][LW-1:0]  s_arlen;
  logic [1:0]          s_arready;
  logic [1:0]          s_rvalid;
  logic [DW-1:0]       s_rdata;
  logic                m_arvalid;
  logic [AW-1:0]       m_araddr;
  logic [LW-1:0]       m_arlen;
  logic [IW-1:0]       m_arid;
  logic                m_arready;
  logic                m_rvalid;
  logic [DW-1:0]       m_rdata;
  logic [IW-1:0]       m_rid;
  logic                m_rready;
  logic                grant_id;
  logic                busy;
  logic                err_rid;

  mem_read_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arid(m_arid),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rready(m_rready), .grant_id(grant_id), .busy(busy), .err_rid(err_rid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Burst-level reference: a burst is either absent, waiting for its address
  // handshake, or draining a count of remaining beats.
  bit            mdl_active   = 1'b0;
  bit            mdl_addr_done = 1'b0;
  bit            mdl_who      = 1'b0;
  bit            mdl_favour   = 1'b0;
  bit            mdl_err      = 1'b0;
  logic [AW-1:0] mdl_addr     = '0;
  int            mdl_len      = 0;
  int            mdl_left     = 0;
  bit [1:0]      mdl_hs       = '0;

  always @(posedge clk) begin
    mdl_hs = '0;
    if (!rst_n) begin
      mdl_active = 1'b0;
      mdl_favour = 1'b0;
      mdl_who    = 1'b0;
      mdl_err    = 1'b0;
    end else if (!mdl_active) begin
      if (s_arvalid != 2'b00) begin
        mdl_who       = s_arvalid[mdl_favour] ? mdl_favour : !mdl_favour;
        mdl_addr      = s_araddr[mdl_who];
        mdl_len       = (s_arlen[mdl_who] == 0) ? 1 : int'(s_arlen[mdl_who]);
        mdl_left      = mdl_len;
        mdl_active    = 1'b1;
        mdl_addr_done = 1'b0;
      end
    end else if (!mdl_addr_done) begin
      if (m_arready) begin
        mdl_addr_done   = 1'b1;
        mdl_hs[mdl_who] = 1'b1;
      end
    end else if (m_rvalid) begin
      if (m_rid != IW'(mdl_who)) mdl_err = 1'b1;
      mdl_left--;
      if (mdl_left == 0) begin
        mdl_active = 1'b0;
        mdl_favour = !mdl_who;
      end
    end
  end

  bit cmp_en = 1'b0;
  int rv_count[2];
  int ar_count[2];

  always @(negedge clk) begin
    logic [1:0] exp_ar;
    logic [1:0] exp_rv;
    logic       exp_arv;
    logic       exp_rr;
    if (cmp_en) begin
      exp_arv = mdl_active && !mdl_addr_done;
      exp_rr  = mdl_active && mdl_addr_done;
      exp_ar  = '0;
      exp_rv  = '0;
      if (exp_arv && m_arready) exp_ar[mdl_who] = 1'b1;
      if (exp_rr && m_rvalid)   exp_rv[mdl_who] = 1'b1;
      check("busy", busy, mdl_active);
      check("m_arvalid", m_arvalid, exp_arv);
      check("m_rready", m_rready, exp_rr);
      check("s_arready", s_arready, exp_ar);
      check("s_rvalid", s_rvalid, exp_rv);
      check("grant_id", grant_id, mdl_who);
      check("err_rid", err_rid, mdl_err);
      if (exp_arv) begin
        check("m_araddr", m_araddr, mdl_addr);
        check("m_arlen", m_arlen, mdl_len[LW-1:0]);
        check("m_arid", m_arid, IW'(mdl_who));
      end
      if (exp_rv != 2'b00) check("s_rdata", s_rdata, m_rdata);
      for (int i = 0; i < 2; i++) begin
        if (s_rvalid[i])  rv_count[i]++;
        if (s_arready[i]) ar_count[i]++;
      end
    end
  end

  logic [1:0] req_pend = '0;

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) if (mdl_hs[i]) req_pend[i] = 1'b0;
    s_arvalid = req_pend;
  endtask

  task automatic request(input int who, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_pend[who] = 1'b1;
    s_araddr[who] = addr;
    s_arlen[who]  = len;
    s_arvalid     = req_pend;
  endtask

  task automatic clear_counts();
    rv_count = '{0, 0};
    ar_count = '{0, 0};
  endtask

  // Memory side: hold off the address for ar_wait cycles, then return one
  // beat for every set bit of mask, one mask bit per cycle.
  task automatic serve(input int ar_wait, input logic [31:0] mask, input logic [IW-1:0] rid);
    m_arready = 1'b0;
    for (int i = 0; i < ar_wait; i++) tick();
    m_arready = 1'b1;
    tick();
    m_arready = 1'b0;
    for (int i = 0; i < 32 && (mask >> i) != 32'd0; i++) begin
      m_rvalid = mask[i];
      m_rdata  = $urandom;
      m_rid    = rid;
      tick();
    end
    m_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_arvalid = '0; s_araddr = '0; s_arlen = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0;
    clear_counts();
    tick(); tick();
    cmp_en = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_s_arready", s_arready, 0);
    check("rst_m_rready", m_rready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_err_rid", err_rid, 0);
    rst_n = 1'b1;

    // Single i_cache burst, address accepted on the second cycle.
    request(0, 26'h0001040, 4'd4);
    tick(); #1;
    check("t1_m_arvalid", m_arvalid, 1);
    check("t1_m_araddr", m_araddr, 26'h0001040);
    check("t1_m_arid", m_arid, 0);
    check("t1_m_arlen", m_arlen, 4);
    clear_counts();
    serve(1, 32'hF, 4'd0); #1;
    check("t1_rvalid0_count", rv_count[0], 4);
    check("t1_rvalid1_count", rv_count[1], 0);
    check("t1_busy_after", busy, 0);

    // Simultaneous requests straight after reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    request(0, 26'h100, 4'd4);
    request(1, 26'h200, 4'd4);
    tick(); #1;
    check("t2_first_grant", grant_id, 0);
    check("t2_first_addr", m_araddr, 26'h100);
    serve(0, 32'hF, 4'd0);
    tick(); #1;
    check("t2_second_grant", grant_id, 1);
    check("t2_second_addr", m_araddr, 26'h200);
    check("t2_second_arid", m_arid, 1);
    serve(0, 32'hF, 4'd1);
    request(0, 26'h140, 4'd2);
    request(1, 26'h240, 4'd2);
    tick(); #1;
    check("t2_rr_back_to_0", grant_id, 0);
    serve(0, 32'h3, 4'd0);
    tick();
    serve(0, 32'h3, 4'd1);

    // Address stalled five cycles; exactly one accept pulse.
    request(1, 26'h3FFFFC0, 4'd7);
    tick();
    clear_counts();
    serve(5, 32'h7F, 4'd1); #1;
    check("t3_arready1_pulses", ar_count[1], 1);
    check("t3_arready0_pulses", ar_count[0], 0);
    check("t3_rvalid1_count", rv_count[1], 7);

    // Gapped beats, zero length, and maximum length.
    request(0, 26'h40, 4'd4);
    tick();
    clear_counts();
    serve(0, 32'h219, 4'd0); #1;
    check("t4_gapped_count", rv_count[0], 4);
    check("t4_gapped_idle", busy, 0);
    request(1, 26'h80, 4'd0);
    tick(); #1;
    check("t4_len0_as_1", m_arlen, 1);
    clear_counts();
    serve(0, 32'h1, 4'd1); #1;
    check("t4_len0_count", rv_count[1], 1);
    check("t4_len0_idle", busy, 0);
    request(0, 26'h1000, 4'd15);
    tick();
    clear_counts();
    serve(2, 32'h7FFF, 4'd0); #1;
    check("t4_len15_count", rv_count[0], 15);
    check("t4_len15_idle", busy, 0);

    // Wrong RID sets a sticky error.
    request(0, 26'h500, 4'd2);
    tick();
    serve(0, 32'h3, 4'd1); #1;
    check("t5_err_set", err_rid, 1);
    request(1, 26'h600, 4'd3);
    tick();
    serve(0, 32'h7, 4'd1);
    request(0, 26'h700, 4'd2);
    tick();
    serve(0, 32'h3, 4'd0); #1;
    check("t5_err_sticky", err_rid, 1);

    // Reset after beat 2 of 4; stray beats afterwards are refused.
    request(0, 26'h800, 4'd4);
    tick();
    m_arready = 1'b1; tick(); m_arready = 1'b0;
    m_rvalid = 1'b1; m_rid = 4'd0;
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    check("t6_busy", busy, 0);
    check("t6_m_rready", m_rready, 0);
    check("t6_m_arvalid", m_arvalid, 0);
    check("t6_s_rvalid", s_rvalid, 0);
    check("t6_err_cleared", err_rid, 0);
    check("t6_grant_id", grant_id, 0);
    clear_counts();
    tick(); tick(); tick(); #1;
    check("t6_stray_rvalid", rv_count[0] + rv_count[1], 0);
    m_rvalid = 1'b0;
    request(0, 26'h900, 4'd1);
    request(1, 26'hA00, 4'd1);
    tick(); #1;
    check("t6_ptr_reset", grant_id, 0);
    serve(0, 32'h1, 4'd0);
    tick();
    serve(0, 32'h1, 4'd1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!req_pend[i] && $urandom_range(0, 99) < 20)
          request(i, AW'($urandom), LW'($urandom_range(0, 15)));
      m_arready = 1'($urandom_range(0, 1));
      m_rvalid  = ($urandom_range(0, 99) < 60);
      m_rdata   = $urandom;
      m_rid     = ($urandom_range(0, 99) < 97) ? IW'(mdl_who) : IW'($urandom);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n = 1'b1;

    // Drain whatever is still pending.
    m_arready = 1'b1;
    m_rvalid  = 1'b1;
    for (int c = 0; c < 80; c++) begin
      m_rid = IW'(mdl_who);
      tick();
    end
    #1;
    check("drain_idle", busy, 0);
    check("drain_no_requests", s_arvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
